// File: rtl/irq_aggregator_pkg.sv
// Shared definitions for the interrupt aggregator: register map, limits and
// the layout of the VECTOR read word.
package irq_aggregator_pkg;

    localparam int MAX_SRC       = 16;
    localparam int DATA_W        = 16;
    localparam int ADDR_W        = 3;

    localparam logic [2:0] ADDR_RAW     = 3'd0;
    localparam logic [2:0] ADDR_PENDING = 3'd1;
    localparam logic [2:0] ADDR_MASK    = 3'd2;
    localparam logic [2:0] ADDR_EDGE    = 3'd3;
    localparam logic [2:0] ADDR_SWTRIG  = 3'd4;
    localparam logic [2:0] ADDR_VECTOR  = 3'd5;
    localparam logic [2:0] ADDR_COUNT   = 3'd6;

    localparam int VEC_VALID_BIT = 15;
    localparam int VEC_IDX_W     = 4;

    // Build the VECTOR read word: valid flag in bit 15, source index in [3:0].
    function automatic logic [DATA_W-1:0] pack_vector(input logic valid,
                                                      input logic [VEC_IDX_W-1:0] idx);
        logic [DATA_W-1:0] v;
        v                  = 16'h0000;
        v[VEC_VALID_BIT]   = valid;
        v[VEC_IDX_W-1:0]   = idx;
        return v;
    endfunction

endpackage

// File: rtl/irq_aggregator_prio_enc.sv
// Lowest-index-first priority encoder. idx is 0 when nothing is active.
module irq_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] active,
    output logic [3:0]   idx,
    output logic         valid
);

    logic found_s;

    // Scan upwards and keep the first active bit found.
    always_comb begin
        idx     = 4'd0;
        found_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (active[i] && !found_s) begin
                idx     = 4'(i);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign valid = |active;

endmodule

// File: rtl/irq_aggregator.sv
// Interrupt aggregator: latches up to 16 sources (source 0 = timer), masks
// them into a single registered CPU interrupt, and exposes pending, mask,
// edge-select, software trigger, priority vector and delivery count registers.
module irq_aggregator
    import irq_aggregator_pkg::*;
#(
    parameter int          NUM_SRC    = 8,
    parameter logic [15:0] EDGE_RESET = 16'h0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic               irq
);

    logic [NUM_SRC-1:0] pending_r;
    logic [NUM_SRC-1:0] mask_r;
    logic [NUM_SRC-1:0] edge_sel_r;
    logic [NUM_SRC-1:0] src_q_r;
    logic [15:0]        count_r;
    logic [15:0]        readdata_r;
    logic               irq_r;

    logic               wr_s;
    logic               wr_pending_s;
    logic               wr_mask_s;
    logic               wr_edge_s;
    logic               wr_swtrig_s;
    logic               wr_count_s;
    logic [NUM_SRC-1:0] wdata_src_s;
    logic [NUM_SRC-1:0] rise_s;
    logic [NUM_SRC-1:0] set_s;
    logic [NUM_SRC-1:0] clr_s;
    logic [NUM_SRC-1:0] pending_next_s;
    logic [NUM_SRC-1:0] active_s;
    logic               irq_next_s;
    logic [15:0]        count_next_s;
    logic [3:0]         vec_idx_s;
    logic               vec_valid_s;
    logic [15:0]        rd_mux_s;
    logic               unused_wdata_s;

    // Zero-extend a per-source vector onto the 16-bit data bus.
    function automatic logic [15:0] zext(input logic [NUM_SRC-1:0] v);
        logic [15:0] r;
        r              = 16'h0000;
        r[NUM_SRC-1:0] = v;
        return r;
    endfunction

    assign wr_s           = chipselect & ~write_n;
    assign wr_pending_s   = wr_s & (address == ADDR_PENDING);
    assign wr_mask_s      = wr_s & (address == ADDR_MASK);
    assign wr_edge_s      = wr_s & (address == ADDR_EDGE);
    assign wr_swtrig_s    = wr_s & (address == ADDR_SWTRIG);
    assign wr_count_s     = wr_s & (address == ADDR_COUNT);
    assign wdata_src_s    = writedata[NUM_SRC-1:0];
    assign unused_wdata_s = ^writedata;

    // Set and clear terms; a set in the same cycle as a W1C keeps the bit.
    always_comb begin
        rise_s = irq_src & ~src_q_r;
        set_s  = (edge_sel_r & rise_s) | (~edge_sel_r & irq_src);
        if (wr_swtrig_s) begin
            set_s = set_s | wdata_src_s;
        end else begin
            set_s = set_s;
        end
        if (wr_pending_s) begin
            clr_s = wdata_src_s;
        end else begin
            clr_s = {NUM_SRC{1'b0}};
        end
        pending_next_s = set_s | (pending_r & ~clr_s);
        active_s       = pending_r & mask_r;
        irq_next_s     = |active_s;
    end

    // Delivery counter: clear wins over increment, increment saturates.
    always_comb begin
        if (wr_count_s) begin
            count_next_s = 16'h0000;
        end else if (irq_next_s && !irq_r && (count_r != 16'hFFFF)) begin
            count_next_s = count_r + 16'd1;
        end else begin
            count_next_s = count_r;
        end
    end

    irq_prio_enc #(
        .N (NUM_SRC)
    ) u_prio_enc (
        .active (active_s),
        .idx    (vec_idx_s),
        .valid  (vec_valid_s)
    );

    // Read mux; sampled into readdata every cycle, reads have no side effects.
    always_comb begin
        case (address)
            ADDR_RAW:     rd_mux_s = zext(irq_src);
            ADDR_PENDING: rd_mux_s = zext(pending_r);
            ADDR_MASK:    rd_mux_s = zext(mask_r);
            ADDR_EDGE:    rd_mux_s = zext(edge_sel_r);
            ADDR_SWTRIG:  rd_mux_s = 16'h0000;
            ADDR_VECTOR:  rd_mux_s = pack_vector(vec_valid_s, vec_idx_s);
            ADDR_COUNT:   rd_mux_s = count_r;
            default:      rd_mux_s = 16'h0000;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r  <= {NUM_SRC{1'b0}};
            mask_r     <= {NUM_SRC{1'b0}};
            edge_sel_r <= EDGE_RESET[NUM_SRC-1:0];
            src_q_r    <= {NUM_SRC{1'b0}};
            count_r    <= 16'h0000;
            readdata_r <= 16'h0000;
            irq_r      <= 1'b0;
        end else begin
            pending_r  <= pending_next_s;
            mask_r     <= wr_mask_s ? wdata_src_s : mask_r;
            edge_sel_r <= wr_edge_s ? wdata_src_s : edge_sel_r;
            src_q_r    <= irq_src;
            count_r    <= count_next_s;
            readdata_r <= rd_mux_s;
            irq_r      <= irq_next_s;
        end
    end

    assign readdata = readdata_r;
    assign irq      = irq_r;

endmodule

// File: tb/tb_irq_aggregator.sv
// Directed self-checking bench for irq_aggregator (NUM_SRC=8, EDGE_RESET=16'h0010).
module tb_irq_aggregator;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic [7:0]  irq_src;
    logic        irq;

    int n_checks;
    int n_fail;

    irq_aggregator #(
        .NUM_SRC    (8),
        .EDGE_RESET (16'h0010)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_src    (irq_src),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic read_check(input string tag, input logic [2:0] a, input logic [15:0] exp);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick();
        chipselect = 1'b0;
        check_eq(tag, readdata, exp);
    endtask

    // One irq 0->1 delivery by toggling mask bit 5 (pending bit 5 is set).
    task automatic irq_pulse();
        bus_write(3'd2, 16'h0020);
        tick();
        bus_write(3'd2, 16'h0000);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 16'h0000;
        irq_src    = 8'h00;
        tick();
        tick();
        reset = 1'b0;

        // 1: reset state of every address
        check_eq("rst_irq", {15'd0, irq}, 16'h0000);
        check_eq("rst_rdata", readdata, 16'h0000);
        read_check("rst_raw",  3'd0, 16'h0000);
        read_check("rst_pend", 3'd1, 16'h0000);
        read_check("rst_mask", 3'd2, 16'h0000);
        read_check("rst_edge", 3'd3, 16'h0010);
        read_check("rst_sw",   3'd4, 16'h0000);
        read_check("rst_vec",  3'd5, 16'h0000);
        read_check("rst_cnt",  3'd6, 16'h0000);
        read_check("rst_a7",   3'd7, 16'h0000);
        bus_write(3'd2, 16'hFFFF);
        read_check("mask_unused", 3'd2, 16'h00FF);
        bus_write(3'd2, 16'h0000);

        // 2: one-cycle pulse on timer source
        bus_write(3'd2, 16'h0001);
        irq_src = 8'h01;
        tick();
        irq_src = 8'h00;
        check_eq("t2_irq_k", {15'd0, irq}, 16'h0000);
        tick();
        check_eq("t2_irq_k1", {15'd0, irq}, 16'h0001);
        read_check("t2_pend", 3'd1, 16'h0001);
        read_check("t2_cnt",  3'd6, 16'h0001);
        read_check("t2_vec",  3'd5, 16'h8000);
        bus_write(3'd1, 16'h0001);
        check_eq("t2_irq_lag", {15'd0, irq}, 16'h0001);
        tick();
        check_eq("t2_irq_off", {15'd0, irq}, 16'h0000);
        read_check("t2_pend0", 3'd1, 16'h0000);

        // 3: level source held high survives W1C
        bus_write(3'd2, 16'h0004);
        irq_src = 8'h04;
        tick();
        tick();
        check_eq("t3_irq", {15'd0, irq}, 16'h0001);
        bus_write(3'd1, 16'h0004);
        read_check("t3_pend_held", 3'd1, 16'h0004);
        check_eq("t3_irq_held", {15'd0, irq}, 16'h0001);
        irq_src = 8'h00;
        bus_write(3'd1, 16'h0004);
        tick();
        check_eq("t3_irq_off", {15'd0, irq}, 16'h0000);
        read_check("t3_pend0", 3'd1, 16'h0000);

        // 4: edge mode, rising edge collides with W1C
        bus_write(3'd3, 16'h0002);
        bus_write(3'd2, 16'h0002);
        irq_src = 8'h02;
        bus_write(3'd1, 16'h0002);
        read_check("t4_pend_coll", 3'd1, 16'h0002);
        tick();
        tick();
        tick();
        check_eq("t4_irq", {15'd0, irq}, 16'h0001);
        read_check("t4_cnt", 3'd6, 16'h0003);
        bus_write(3'd1, 16'h0002);
        tick();
        read_check("t4_pend_clr", 3'd1, 16'h0000);
        check_eq("t4_irq_off", {15'd0, irq}, 16'h0000);
        read_check("t4_cnt_hold", 3'd6, 16'h0003);
        irq_src = 8'h00;

        // 5: priority and masking
        bus_write(3'd2, 16'h0020);
        bus_write(3'd4, 16'h0028);
        read_check("t5_vec5", 3'd5, 16'h8005);
        bus_write(3'd2, 16'h00FF);
        read_check("t5_vec3", 3'd5, 16'h8003);
        check_eq("t5_irq", {15'd0, irq}, 16'h0001);
        read_check("t5_sw_rd", 3'd4, 16'h0000);
        bus_write(3'd2, 16'h0000);
        tick();
        check_eq("t5_irq_off", {15'd0, irq}, 16'h0000);
        read_check("t5_pend", 3'd1, 16'h0028);
        read_check("t5_vec_none", 3'd5, 16'h0000);
        read_check("t5_cnt", 3'd6, 16'h0004);
        irq_src = 8'hA5;
        read_check("t5_raw", 3'd0, 16'h00A5);
        irq_src = 8'h00;

        // 6: counter clear, saturation, clear beats increment
        bus_write(3'd6, 16'h1234);
        read_check("t6_cnt_clr", 3'd6, 16'h0000);
        force dut.count_r = 16'hFFFD;
        tick();
        release dut.count_r;
        irq_pulse();
        irq_pulse();
        read_check("t6_cnt_sat", 3'd6, 16'hFFFF);
        irq_pulse();
        read_check("t6_cnt_stay", 3'd6, 16'hFFFF);
        bus_write(3'd2, 16'h0020);
        bus_write(3'd6, 16'h0000);
        check_eq("t6_irq_rise", {15'd0, irq}, 16'h0001);
        read_check("t6_cnt_coll", 3'd6, 16'h0000);

        // Reset mid-operation discards pending state
        check_eq("mid_irq_pre", {15'd0, irq}, 16'h0001);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mid_irq", {15'd0, irq}, 16'h0000);
        read_check("mid_pend", 3'd1, 16'h0000);
        read_check("mid_mask", 3'd2, 16'h0000);
        read_check("mid_edge", 3'd3, 16'h0010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
